uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide transmit FIFO feeding an 8-bit UART serialiser with
// optional parity.
//
// Parameters
//   DEPTH : transmit FIFO depth in bytes (power of two, >= 2)
//   OSR   : sample_clk cycles per serial bit
//
// Ports
//   sample_clk  : sole clock, all state updates on its rising edge
//   rst         : asynchronous, active-high reset
//   in_data     : byte to transmit
//   in_valid    : in_data is valid this cycle
//   in_ready    : FIFO not full (combinational from the occupancy count)
//   parity_en   : 1 = append a parity bit after the data bits
//   parity_kind : 1 = odd parity, 0 = even parity
//   txd         : registered serial line, idle high
//   busy        : registered, high whenever the FSM is not in IDLE
//   fifo_level  : current FIFO occupancy, 0..DEPTH
module uart_tx #(
  parameter int DEPTH = 4,
  parameter int OSR   = 16
) (
  input  logic                   sample_clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   parity_en,
  input  logic                   parity_kind,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(OSR - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Serialiser state
  state_t        state_reg, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic          par_en_reg, par_en_next;
  logic          par_bit_reg, par_bit_next;
  logic          txd_reg, txd_next;
  logic          busy_reg;
  logic          tick_last;

  // ---------------------------------------------------------------- FIFO
  // A full FIFO refuses the byte even when a pop happens on the same edge,
  // because in_ready depends only on the count before the edge.
  assign in_ready   = (level_reg != LEVEL_FULL);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr_reg];
  assign fifo_level = level_reg;

  always_ff @(posedge sample_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // ---------------------------------------------------------- serialiser
  assign tick_last = (tick_reg == TICK_LAST);

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    tick_next    = tick_reg + TW'(1);
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
    txd_next     = txd_reg;
    pop          = 1'b0;

    case (state_reg)
      IDLE: begin
        tick_next = '0;
        txd_next  = 1'b1;
        pop       = (level_reg != '0);
      end
      START: begin
        if (tick_last) begin
          tick_next    = '0;
          bit_cnt_next = '0;
          txd_next     = shift_reg[0];
          state_next   = DATA;
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_next = '0;
          if (bit_cnt_reg == 3'd7) begin
            txd_next   = par_en_reg ? par_bit_reg : 1'b1;
            state_next = par_en_reg ? PARITY : STOP;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            txd_next     = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (tick_last) begin
          tick_next  = '0;
          txd_next   = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick_last) begin
          tick_next  = '0;
          txd_next   = 1'b1;
          state_next = IDLE;
          // Back-to-back frames: start the next one with no idle gap.
          pop        = (level_reg != '0);
        end
      end
      default: begin
        tick_next    = '0;
        bit_cnt_next = '0;
        txd_next     = 1'b1;
        state_next   = IDLE;
      end
    endcase

    // Frame start is shared by IDLE and end-of-STOP. Parity settings are
    // captured here so changes mid-frame only affect later frames.
    if (pop) begin
      shift_next   = head;
      par_en_next  = parity_en;
      par_bit_next = parity_kind ^ (^head);
      bit_cnt_next = '0;
      tick_next    = '0;
      txd_next     = 1'b0;
      state_next   = START;
    end
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tick_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      txd_reg     <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tick_reg    <= tick_next;
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
      txd_reg     <= txd_next;
      busy_reg    <= (state_next != IDLE);
    end
  end

  assign txd  = txd_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a scoreboard. Each issued byte pushes
// its expected frame (data, parity setting, hand-computed parity bit, and
// whether it must follow the previous stop bit with no gap) into a queue;
// an independent serial monitor decodes txd and compares each frame.
module tb_uart_tx;

  localparam int DEPTH = 4;
  localparam int OSR   = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       pbit;
    logic       contig;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       parity_en;
  logic       parity_kind;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_level;

  int   checks;
  int   errors;
  int   frame_count;
  exp_t sb[$];

  uart_tx #(.DEPTH(DEPTH), .OSR(OSR)) dut (
    .sample_clk  (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .parity_en   (parity_en),
    .parity_kind (parity_kind),
    .txd         (txd),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(20000 * 10);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Holds in_valid until the DUT accepts; returns 1 ns after the accepting edge.
  task automatic push(input logic [7:0] b);
    int  w;
    bit  acc;
    w   = 0;
    acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && w < 2000) begin
      @(negedge clk);
      acc = in_ready;
      w++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no accept for %0h, expected accept", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic pbit, input logic contig);
    sb.push_back('{data: b, pe: parity_en, pbit: pbit, contig: contig});
    push(b);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while ((busy || sb.size() != 0) && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({name, "_idle_busy"}, busy, 0);
  endtask

  // Single frame from an idle, empty block: checks acceptance, latency and
  // the length of the busy window.
  task automatic frame_single(input logic [7:0] b, input logic pbit, input int exp_len,
                              input string name);
    int cnt;
    send(b, pbit, 1'b0);
    chk({name, "_level_after_push"}, fifo_level, 1);
    @(posedge clk);
    #1;
    chk({name, "_latency_txd"}, txd, 0);
    chk({name, "_latency_busy"}, busy, 1);
    cnt = 1;
    while (busy && cnt < 2000) begin
      @(posedge clk);
      #1;
      if (busy) cnt++;
    end
    chk({name, "_busy_len"}, cnt, exp_len);
    chk({name, "_txd_idle"}, txd, 1);
  endtask

  // Serial monitor / reference receiver, sampling on the falling edge.
  initial begin : monitor
    exp_t        cur;
    bit          cur_valid;
    bit          active;
    bit          glitch;
    int          pos;
    int          nbits;
    int          b;
    int          idle_cnt;
    logic [10:0] bits;
    active    = 1'b0;
    glitch    = 1'b0;
    cur_valid = 1'b0;
    cur       = '0;
    pos       = 0;
    nbits     = 10;
    idle_cnt  = 0;
    bits      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active   = 1'b0;
        idle_cnt = 0;
        sb.delete();
      end else if (!active) begin
        if (txd == 1'b0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got start bit, expected idle line");
            cur_valid = 1'b0;
            nbits     = 10;
          end else begin
            cur       = sb.pop_front();
            cur_valid = 1'b1;
            nbits     = cur.pe ? 11 : 10;
            if (cur.contig) begin
              chk($sformatf("frame%0d_gap", frame_count), idle_cnt, 0);
            end
          end
          bits    = '0;
          pos     = 1;
          glitch  = 1'b0;
          active  = 1'b1;
        end else begin
          idle_cnt++;
        end
      end else begin
        b = pos / OSR;
        if (pos % OSR == 0) begin
          bits[b] = txd;
        end else if (txd !== bits[b]) begin
          glitch = 1'b1;
        end
        pos++;
        if (pos == nbits * OSR) begin
          active   = 1'b0;
          idle_cnt = 0;
          if (cur_valid) begin
            chk($sformatf("frame%0d_data", frame_count), bits[8:1], cur.data);
            if (cur.pe) begin
              chk($sformatf("frame%0d_parity", frame_count), bits[9], cur.pbit);
            end
            chk($sformatf("frame%0d_stop", frame_count), bits[nbits-1], 1);
            chk($sformatf("frame%0d_bit_width", frame_count), glitch, 0);
            frame_count++;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int low_cnt;
    checks      = 0;
    errors      = 0;
    frame_count = 0;
    rst         = 1'b1;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    parity_en   = 1'b0;
    parity_kind = 1'b0;

    #12;
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_level", fifo_level, 0);
    #5;
    rst = 1'b0;

    // 0xA5, parity off: first push right after reset release, 160-cycle frame.
    frame_single(8'hA5, 1'b0, 10 * OSR, "a5");

    // Parity: 0x03 odd -> 1, 0x03 even -> 0, 0x07 even -> 1.
    parity_en   = 1'b1;
    parity_kind = 1'b1;
    frame_single(8'h03, 1'b1, 11 * OSR, "p03_odd");
    parity_kind = 1'b0;
    frame_single(8'h03, 1'b0, 11 * OSR, "p03_even");
    frame_single(8'h07, 1'b1, 11 * OSR, "p07_even");

    // Loopback set, odd parity: all three bytes have an even number of ones.
    parity_kind = 1'b1;
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b1);
    wait_idle("loop");

    // Burst beyond the FIFO depth, parity off.
    parity_en = 1'b0;
    send(8'h3C, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b1);
    send(8'h81, 1'b0, 1'b1);
    send(8'h7E, 1'b0, 1'b1);
    send(8'h01, 1'b0, 1'b1);
    chk("burst_level_full", fifo_level, 4);
    chk("burst_in_ready_full", in_ready, 0);
    send(8'h80, 1'b0, 1'b1);
    chk("burst_level_refill", fifo_level, 4);
    wait_idle("burst");

    // parity_kind toggled mid-frame: 0x01 odd -> 0, then 0x01 even -> 1.
    parity_en   = 1'b1;
    parity_kind = 1'b1;
    send(8'h01, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    parity_kind = 1'b0;
    wait_idle("toggle");

    // Reset at cycle 70 of a frame with two bytes still queued.
    parity_en = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    repeat (68) @(posedge clk);
    #1;
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_level", fifo_level, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    low_cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    chk("post_rst_txd_low_cycles", low_cnt, 0);
    chk("post_rst_busy", busy, 0);

    chk("frames_received", frame_count, 15);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
